// File: rtl/vram_fetch_sched.sv
// Purpose : shares the single-port VRAM between video byte fetches and a CPU port.
// Latency : video issue -> pixel_code is 3 cycles; CPU req -> cpu_ack is 2 cycles, or 3 on a video collision.
// Backpressure: cpu_req is held until cpu_ack; a video issue cycle stalls a pending CPU request by one cycle.
//
// Ports:
//   pixel_clock, reset             : single clock, synchronous active-high reset
//   graph_pixel, graph_line        : raster position driving the video fetch slots
//   display_en, mode, vdiv         : fetch enable, pixel format and line repeat (mode/vdiv shadowed per line)
//   cpu_req/we/addr/wdata          : CPU access request, held until cpu_ack
//   cpu_ack, cpu_rdata             : 1-cycle completion pulse and read data
//   vram_addr/we/wdata, vram_rdata : VRAM macro port (synchronous read, 1-cycle latency)
//   pixel_code                     : fetched byte for the pixel serializer
// Optional build macro BLANK_FILL_EN: load BLANK_CODE into pixel_code on phase-3 cycles while display_en=0.

module vram_fetch_sched #(
  parameter int ADDR_W = 13,
  parameter logic [ADDR_W-1:0] VRAM_BASE = '0
`ifdef BLANK_FILL_EN
  ,
  parameter logic [7:0] BLANK_CODE = 8'h00
`endif
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic [8:0]        graph_pixel,
  input  logic [7:0]        graph_line,
  input  logic              display_en,
  input  logic [1:0]        mode,
  input  logic [1:0]        vdiv,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  output logic [7:0]        pixel_code
);

  // The CPU access is issued on the edge that leaves C_IDLE; C_WAIT is the
  // cycle its address sits on the RAM, C_ACK the cycle its read data returns.
  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WAIT = 2'd1,
    C_ACK  = 2'd2
  } cpu_state_t;

  cpu_state_t        cpu_state;
  logic              cpu_rd;
  logic [7:0]        rdata_q;
  logic [1:0]        mode_sh;
  logic [1:0]        vdiv_sh;

  logic              p16;
  logic [4:0]        phase;
  logic [4:0]        col;
  logic [7:0]        row;
  logic [ADDR_W-1:0] row_ext;
  logic [ADDR_W-1:0] col_ext;
  logic [ADDR_W-1:0] video_addr;
  logic              v_issue;
  logic              v_capt;

  // Slot decode from the per-line shadow copies, so a mid-line mode change
  // only shows up from the next line.
  always_comb begin
    p16 = (mode_sh == 2'd1) || (mode_sh == 2'd3);
    if (p16) begin
      phase = {1'b0, graph_pixel[3:0]};
      col   = graph_pixel[8:4];
    end else begin
      phase = graph_pixel[4:0];
      col   = {1'b0, graph_pixel[8:5]};
    end
    row        = graph_line >> vdiv_sh;
    row_ext    = ADDR_W'(row);
    col_ext    = ADDR_W'(col);
    video_addr = VRAM_BASE + (p16 ? (row_ext << 5) : (row_ext << 4)) + col_ext;
    v_issue    = display_en && (phase == 5'd1);
    v_capt     = display_en && (phase == 5'd3);
  end

  // Read data is only on vram_rdata during the ack cycle, so it is bypassed
  // there and held in rdata_q from then on.
  assign cpu_rdata = (cpu_ack && cpu_rd) ? vram_rdata : rdata_q;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      cpu_state  <= C_IDLE;
      cpu_rd     <= 1'b0;
      cpu_ack    <= 1'b0;
      rdata_q    <= 8'h00;
      vram_addr  <= '0;
      vram_we    <= 1'b0;
      vram_wdata <= 8'h00;
      pixel_code <= 8'h00;
      mode_sh    <= 2'd0;
      vdiv_sh    <= 2'd0;
    end else begin
      if (graph_pixel == 9'd0) begin
        mode_sh <= mode;
        vdiv_sh <= vdiv;
      end

      cpu_ack <= 1'b0;
      case (cpu_state)
        C_IDLE: begin
          if (cpu_req && !v_issue) begin
            vram_addr  <= cpu_addr;
            vram_we    <= cpu_we;
            vram_wdata <= cpu_wdata;
            cpu_rd     <= !cpu_we;
            cpu_state  <= C_WAIT;
          end
        end
        C_WAIT: begin
          vram_we   <= 1'b0;
          cpu_ack   <= 1'b1;
          cpu_state <= C_ACK;
        end
        C_ACK: begin
          // cpu_req is ignored here; the next request is taken from C_IDLE.
          if (cpu_rd) rdata_q <= vram_rdata;
          cpu_state <= C_IDLE;
        end
        default: cpu_state <= C_IDLE;
      endcase

      // Video issue overrides the address port; a CPU access can only be in
      // C_WAIT here, whose address cycle has already been used.
      if (v_issue) begin
        vram_addr <= video_addr;
        vram_we   <= 1'b0;
      end

      if (v_capt) begin
        pixel_code <= vram_rdata;
      end
`ifdef BLANK_FILL_EN
      else if (!display_en && (phase == 5'd3)) begin
        pixel_code <= BLANK_CODE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_vram_fetch_sched.sv
// Bench for vram_fetch_sched: behavioural VRAM, video and CPU scoreboards.
// Video bytes are pushed at the phase-1 issue and popped at the phase-3 capture;
// CPU transactions are pushed at request and popped when cpu_ack is seen.

module tb_vram_fetch_sched;

  localparam int AW = 13;
  localparam logic [AW-1:0] BASE = '0;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } pix_t;

  typedef struct {
    bit         rd;
    logic [7:0] d;
  } cpu_t;

  logic          pixel_clock = 1'b0;
  logic          reset;
  logic [8:0]    graph_pixel;
  logic [7:0]    graph_line;
  logic          display_en;
  logic [1:0]    mode;
  logic [1:0]    vdiv;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [7:0]    vram_wdata;
  logic [7:0]    vram_rdata;
  logic [7:0]    pixel_code;

  vram_fetch_sched #(
    .ADDR_W   (AW),
    .VRAM_BASE(BASE)
  ) dut (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .graph_pixel(graph_pixel),
    .graph_line (graph_line),
    .display_en (display_en),
    .mode       (mode),
    .vdiv       (vdiv),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .pixel_code (pixel_code)
  );

  always #5 pixel_clock = ~pixel_clock;

  // VRAM macro: synchronous read, read-before-write.
  logic [7:0] mem [0:(1<<AW)-1];
  int wr_cnt = 0;
  always @(posedge pixel_clock) begin
    vram_rdata <= mem[vram_addr];
    if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  pix_t pix_q[$];
  cpu_t cpu_q[$];

  logic [8:0] cur_pix;
  int         cur_line;
  logic [1:0] sh_mode;
  logic [1:0] sh_vdiv;
  logic [7:0] last_pix;

  function automatic logic [7:0] pat(input int i);
    int v;
    v = (i * 7 + 3) % 256;
    return v[7:0];
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [8:0] p);
    int row, adr;
    row = cur_line / (1 << sh_vdiv);
    if (sh_mode == 2'd1 || sh_mode == 2'd3) adr = int'(BASE) + row * 32 + int'(p) / 16;
    else                                    adr = int'(BASE) + row * 16 + int'(p) / 32;
    return adr[AW-1:0];
  endfunction

  // CPU completions: every ack must match a pending request.
  always @(negedge pixel_clock) begin
    if (cpu_ack) begin
      if (cpu_q.size() == 0) begin
        chk("ack_unexpected", cpu_ack, 0);
      end else begin
        cpu_t it;
        it = cpu_q.pop_front();
        if (it.rd) chk("cpu_rdata", cpu_rdata, it.d);
      end
    end
  end

  // One pixel cycle: drive graph_pixel, clock it, check what the edge produced.
  task automatic drive_pix();
    logic [8:0]    p;
    logic [4:0]    ph;
    logic [AW-1:0] a;
    pix_t          it;
    bit            rst;
    bit            de;
    p   = cur_pix;
    rst = reset;
    de  = display_en;
    graph_pixel = p;
    ph = (sh_mode == 2'd1 || sh_mode == 2'd3) ? {1'b0, p[3:0]} : p[4:0];
    if (!rst && de && ph == 5'd1) begin
      a    = model_addr(p);
      it.a = a;
      it.d = mem[a];
      pix_q.push_back(it);
    end
    @(posedge pixel_clock);
    #1;
    cur_pix = p + 9'd1;
    if (rst) begin
      sh_mode  = 2'd0;
      sh_vdiv  = 2'd0;
      last_pix = 8'h00;
      pix_q.delete();
      return;
    end
    if (p == 9'd0) begin
      sh_mode = mode;
      sh_vdiv = vdiv;
    end
    if (de && ph == 5'd1) begin
      chk("v_addr", vram_addr, pix_q[$].a);
      chk("v_we", vram_we, 0);
    end
    if (ph == 5'd3) begin
      if (de) begin
        if (pix_q.size() == 0) begin
          chk("v_capt_pending", pix_q.size(), 1);
        end else begin
          it = pix_q.pop_front();
          last_pix = it.d;
          chk("pixel_code", pixel_code, it.d);
        end
      end else begin
`ifdef BLANK_FILL_EN
        last_pix = 8'h00;
`endif
        chk("pix_hold", pixel_code, last_pix);
      end
    end
  endtask

  task automatic run_to(input logic [8:0] t);
    while (cur_pix != t) drive_pix();
  endtask

  task automatic cpu_xfer(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input int exp_lat);
    int   lat;
    bit   got;
    cpu_t it;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_req   = 1'b1;
    it.rd = !we;
    it.d  = exp_rd;
    cpu_q.push_back(it);
    lat = 0;
    got = 0;
    while (!got && lat < 8) begin
      drive_pix();
      lat++;
      if (cpu_ack) got = 1;
    end
    cpu_req = 1'b0;
    chk("ack_seen", got, 1);
    chk("ack_latency", lat, exp_lat);
    if (!we) begin
      drive_pix();
      chk("rdata_hold", cpu_rdata, exp_rd);
    end
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = pat(i);
    mem[13'h0A3]  = 8'h5A;
    mem[13'h025]  = 8'h77;
    mem[13'h200]  = 8'hC4;
    mem[13'h1234] = 8'h9B;

    reset = 1'b1; display_en = 1'b0; mode = 2'd0; vdiv = 2'd0;
    graph_line = 8'd0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    cur_pix = 9'd0; cur_line = 0; sh_mode = 2'd0; sh_vdiv = 2'd0; last_pix = 8'h00;
    drive_pix();
    drive_pix();
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_vram_wdata", vram_wdata, 0);
    chk("rst_pixel_code", pixel_code, 0);
    reset = 1'b0;

    // Mode 3, line 5: 32 bytes per line.
    cur_pix = 9'd0;
    mode = 2'd3; vdiv = 2'd0; graph_line = 8'd5; cur_line = 5; display_en = 1'b1;
    run_to(9'h032);
    chk("m3_addr_a3", vram_addr, 13'h0A3);
    run_to(9'h034);
    chk("m3_pix_5a", pixel_code, 8'h5A);

    // CPU write raised on a video issue cycle: waits one cycle, single write strobe.
    run_to(9'h041);
    wr0 = wr_cnt;
    cpu_xfer(1'b1, 13'h100, 8'h33, 8'h00, 3);
    drive_pix();
    chk("wr_count", wr_cnt, wr0 + 1);
    chk("wr_data", mem[13'h100], 8'h33);

    // CPU read issued at phase 0: no collision with the video slot.
    run_to(9'h050);
    cpu_xfer(1'b0, 13'h1234, 8'h00, 8'h9B, 2);

    // Mode 0, vdiv 2, line 9; mode switched to 3 mid-line.
    run_to(9'h000);
    mode = 2'd0; vdiv = 2'd2; graph_line = 8'd9; cur_line = 9;
    run_to(9'h080);
    mode = 2'd3;
    run_to(9'h0A2);
    chk("m0_addr_25", vram_addr, 13'h025);
    run_to(9'h0A4);
    chk("m0_pix_77", pixel_code, 8'h77);
    run_to(9'h000);
    graph_line = 8'd10; cur_line = 10;
    run_to(9'h042);
    chk("m3_next_line_addr", vram_addr, 13'h044);

    // Blanking: CPU owns every cycle, pixel_code holds.
    run_to(9'h050);
    display_en = 1'b0;
    cpu_xfer(1'b0, 13'h200, 8'h00, 8'hC4, 2);
    cpu_xfer(1'b1, 13'h1F0, 8'hA5, 8'h00, 2);
    cpu_xfer(1'b0, 13'h1F0, 8'h00, 8'hA5, 3);
    run_to(9'h080);

    // Reset landing in C_WAIT of a write: no ack, outputs cleared.
    cpu_we = 1'b1; cpu_addr = 13'h150; cpu_wdata = 8'hEE; cpu_req = 1'b1;
    drive_pix();
    chk("c_issue_we", vram_we, 1);
    chk("c_issue_addr", vram_addr, 13'h150);
    reset = 1'b1; cpu_req = 1'b0;
    drive_pix();
    chk("rst2_cpu_ack", cpu_ack, 0);
    chk("rst2_cpu_rdata", cpu_rdata, 0);
    chk("rst2_vram_addr", vram_addr, 0);
    chk("rst2_vram_we", vram_we, 0);
    chk("rst2_vram_wdata", vram_wdata, 0);
    chk("rst2_pixel_code", pixel_code, 0);
    reset = 1'b0;
    repeat (4) drive_pix();

    // Reset in the issue cycle: the write never happens.
    wr0 = wr_cnt;
    reset = 1'b1;
    cpu_we = 1'b1; cpu_addr = 13'h160; cpu_wdata = 8'h11; cpu_req = 1'b1;
    drive_pix();
    chk("rst3_vram_we", vram_we, 0);
    reset = 1'b0; cpu_req = 1'b0;
    repeat (4) drive_pix();
    chk("rst3_wr_count", wr_cnt, wr0);
    chk("rst3_mem", mem[13'h160], pat(13'h160));

    // CPU re-requests after reset.
    cpu_xfer(1'b0, 13'h200, 8'h00, 8'hC4, 2);
    repeat (3) drive_pix();
    chk("cpu_q_empty", cpu_q.size(), 0);
    chk("pix_q_empty", pix_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
